c_trace_fifo: RTL and testbench
===============================

C_TRACE_FIFO -- requirements
Module: c_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of trace entries; power of two, 2..64.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port C, input, 8: state-code output of the upstream state_machine, sampled every clk edge.
REQ-005 Port rd_en, input, 1: consumer pop request.
REQ-006 Port dout, output, 8: C code of the oldest entry (show-ahead).
REQ-007 Port dstamp, output, 8: cycle stamp of the oldest entry.
REQ-008 Port empty, output, 1: no entries held.
REQ-009 Port full, output, 1: DEPTH entries held.
REQ-010 Port count, output, log2(DEPTH)+1: number of entries held, 0..DEPTH.
REQ-011 Port overflow, output, 1: sticky flag, at least one entry dropped since reset.

Function
REQ-012 Stamp counter SHALL increment by 1 every clk edge, 8 bits, wrapping 255 -> 0.
REQ-013 Register prev_c SHALL hold C from the previous edge.
REQ-014 Flag first SHALL be 1 after reset and clear on the first clk edge.
REQ-015 A push SHALL occur at an edge when first = 1 or C != prev_c, writing {C, current stamp}.
REQ-016 Repeated identical C values SHALL NOT be pushed.
REQ-017 A pop SHALL occur at an edge when rd_en = 1 and empty = 0; rd_en while empty SHALL be ignored without error.
REQ-018 dout/dstamp SHALL present the head entry combinationally from storage whenever empty = 0; value is don't-care when empty = 1.
REQ-019 A pushed entry SHALL be visible on dout the cycle after the push edge (latency 1), with empty deasserted the same cycle.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH: both performed, count unchanged.
REQ-021 Push while full with pop at the same edge: both performed, count stays DEPTH, no overflow.
REQ-022 Push while full without pop: entry dropped, storage unchanged, overflow set to 1.
REQ-023 overflow SHALL clear only on reset.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; full = (count == DEPTH), empty = (count == 0).
REQ-025 Entries SHALL be popped in push order (FIFO).

Reset
REQ-026 Asserting rst SHALL immediately force: count = 0, empty = 1, full = 0, overflow = 0, stamp = 0, prev_c = 0, first = 1, pointers = 0.
REQ-027 Reset mid-operation SHALL discard all held entries; storage contents need not be cleared.
REQ-028 While rst = 1, no push or pop SHALL occur; the first push happens on the first edge after rst deasserts.

Configuration
REQ-029 Macro C_TRACE_STAMP_EN SHALL select stamping.
REQ-030 With C_TRACE_STAMP_EN defined: behaviour is as per REQ-012 and REQ-015; entries are 16 bits wide.
REQ-031 Without C_TRACE_STAMP_EN: no stamp counter or stamp storage; entries are 8 bits wide; dstamp is tied to 8'h00; all other behaviour is unchanged.

Verification
REQ-032 Reset release, C held at 8'h01 for 5 cycles -> exactly one entry, dout = 8'h01, dstamp = 8'h00, count = 1.
REQ-033 C sequence 01, 04, 04, 20, 08 on consecutive edges after reset -> entries 01/0, 04/1, 20/3, 08/4, popped in that order.
REQ-034 C changing every cycle with no rd_en for DEPTH+2 cycles -> full = 1, count = DEPTH, overflow = 1, first DEPTH codes retained.
REQ-035 Full FIFO with C changing and rd_en = 1 -> count stays DEPTH, overflow stays 0, dout advances each cycle.
REQ-036 rst pulsed mid-cycle with count = 3 -> empty = 1 and count = 0 immediately, before the next edge; the next edge pushes the current C.
REQ-037 Run 300 cycles with a change at cycle 260, C_TRACE_STAMP_EN defined -> dstamp = 260 mod 256 = 4; without the macro -> dstamp = 0.

Source files
------------

// File: rtl/c_trace_fifo.sv
// ============================================================================
// Module   : c_trace_fifo
// Purpose  : Change-only trace FIFO for an upstream state code; optional
//            cycle stamping selected by macro C_TRACE_STAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module c_trace_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               C,
  input  logic                     rd_en,
  output logic [7:0]               dout,
  output logic [7:0]               dstamp,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_CW = C_AW + 1;
`ifdef C_TRACE_STAMP_EN
  localparam int C_EW = 16;
`else
  localparam int C_EW = 8;
`endif

  logic [C_EW-1:0] r_mem [DEPTH];
  logic [C_AW-1:0] r_wptr;
  logic [C_AW-1:0] r_rptr;
  logic [C_CW-1:0] r_count;
  logic [7:0]      r_prev_c;
  logic            r_first;
  logic            r_overflow;

  logic            w_push_req;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_full;
  logic            w_empty;
  logic [C_EW-1:0] w_entry;

  assign w_full     = (r_count == C_CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push_req = r_first | (C != r_prev_c);
  assign w_pop      = rd_en & ~w_empty;
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

`ifdef C_TRACE_STAMP_EN
  logic [7:0] r_stamp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stamp <= 8'd0;
    end else begin
      r_stamp <= r_stamp + 8'd1;
    end
  end

  assign w_entry = {C, r_stamp};
  assign dstamp  = r_mem[r_rptr][7:0];
`else
  assign w_entry = C;
  assign dstamp  = 8'h00;
`endif

  assign dout     = r_mem[r_rptr][C_EW-1 -: 8];
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

  // Storage is not reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_prev_c   <= 8'd0;
      r_first    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_prev_c <= C;
      r_first  <= 1'b0;
      if (w_push) begin
        r_wptr <= r_wptr + C_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_AW'(1);
      end
      r_count <= r_count + C_CW'(w_push) - C_CW'(w_pop);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_c_trace_fifo.sv
// ============================================================================
// Module   : tb_c_trace_fifo
// Purpose  : Self-checking bench for c_trace_fifo: queue-based reference
//            model compared every cycle, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_c_trace_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [7:0]    C;
  logic          rd_en;
  logic [7:0]    dout;
  logic [7:0]    dstamp;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;

  c_trace_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .C        (C),
    .rd_en    (rd_en),
    .dout     (dout),
    .dstamp   (dstamp),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stamp seen on dstamp for an entry pushed at stamp value s.
  function automatic int exps(input int s);
`ifdef C_TRACE_STAMP_EN
    return s % 256;
`else
    return 0;
`endif
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int code;
    int stamp;
  } ent_t;

  ent_t m_q[$];
  int   m_stamp = 0;
  int   m_prev  = 0;
  bit   m_first = 1'b1;
  bit   m_ovf   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_stamp = 0;
      m_prev  = 0;
      m_first = 1'b1;
      m_ovf   = 1'b0;
    end else begin
      int   sz;
      bit   req;
      bit   pop;
      ent_t e;
      sz  = m_q.size();
      req = m_first || (int'(C) != m_prev);
      pop = rd_en && (sz > 0);
      if (pop) void'(m_q.pop_front());
      if (req) begin
        if (sz < DEPTH || pop) begin
          e.code  = int'(C);
          e.stamp = exps(m_stamp);
          m_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_prev  = int'(C);
      m_first = 1'b0;
      m_stamp = (m_stamp + 1) % 256;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_count", int'(count), m_q.size());
      check("cmp_empty", int'(empty), int'(m_q.size() == 0));
      check("cmp_full", int'(full), int'(m_q.size() == DEPTH));
      check("cmp_overflow", int'(overflow), int'(m_ovf));
      if (m_q.size() > 0) begin
        check("cmp_dout", int'(dout), m_q[0].code);
        check("cmp_dstamp", int'(dstamp), m_q[0].stamp);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Apply reset for one cycle, release with code c shortly after a negedge.
  task automatic do_reset(input logic [7:0] c);
    @(negedge clk);
    #1 rst = 1'b1;
    rd_en = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    C = c;
  endtask

  task automatic step(input logic [7:0] c, input logic rd);
    @(negedge clk);
    #1 C = c;
    rd_en = rd;
  endtask

  initial begin
    logic [7:0] seq [5];
    logic [7:0] codes [4];
    int         stamps [4];

    rst   = 1'b1;
    C     = 8'h00;
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);

    // Constant code after release: one entry only.
    #1 rst = 1'b0;
    C = 8'h01;
    repeat (5) @(negedge clk);
    check("hold_count", int'(count), 1);
    check("hold_dout", int'(dout), 8'h01);
    check("hold_dstamp", int'(dstamp), exps(0));

    // Duplicate suppression and FIFO order.
    seq    = '{8'h01, 8'h04, 8'h04, 8'h20, 8'h08};
    codes  = '{8'h01, 8'h04, 8'h20, 8'h08};
    stamps = '{0, 1, 3, 4};
    do_reset(seq[0]);
    for (int i = 1; i < 5; i++) step(seq[i], 1'b0);
    @(negedge clk);
    check("seq_count", int'(count), 4);
    #1 rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("seq_dout", int'(dout), int'(codes[i]));
      check("seq_dstamp", int'(dstamp), exps(stamps[i]));
    end
    @(negedge clk);
    check("seq_drained", int'(empty), 1);
    @(negedge clk);
    check("seq_rd_empty_cnt", int'(count), 0);

    // Overflow: DEPTH+2 distinct codes, no reads.
    do_reset(8'h01);
    for (int i = 1; i < DEPTH + 2; i++) step(8'(i + 1), 1'b0);
    @(negedge clk);
    check("ovf_full", int'(full), 1);
    check("ovf_count", int'(count), DEPTH);
    check("ovf_flag", int'(overflow), 1);
    #1 rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) @(negedge clk);
      check("ovf_retained", int'(dout), i + 1);
    end
    @(negedge clk);
    check("ovf_sticky", int'(overflow), 1);
    check("ovf_empty", int'(empty), 1);

    // Full with simultaneous read: no drop, head advances.
    do_reset(8'h10);
    for (int i = 1; i < DEPTH; i++) step(8'(8'h10 + i), 1'b0);
    @(negedge clk);
    check("fr_full", int'(full), 1);
    for (int k = 0; k < 4; k++) begin
      #1 C = 8'(8'h10 + DEPTH + k);
      rd_en = 1'b1;
      @(negedge clk);
      check("fr_count", int'(count), DEPTH);
      check("fr_overflow", int'(overflow), 0);
      check("fr_dout", int'(dout), 8'h10 + k + 1);
    end

    // Asynchronous reset mid-cycle with three entries held.
    do_reset(8'h31);
    step(8'h32, 1'b0);
    step(8'h33, 1'b0);
    @(negedge clk);
    check("ar_count_before", int'(count), 3);
    #2 rst = 1'b1;
    #1;
    check("ar_empty_now", int'(empty), 1);
    check("ar_count_now", int'(count), 0);
    #1 rst = 1'b0;
    C = 8'h55;
    @(negedge clk);
    check("ar_repush_cnt", int'(count), 1);
    check("ar_repush_dout", int'(dout), 8'h55);
    check("ar_repush_stamp", int'(dstamp), exps(0));

    // Stamp wrap: change at edge 260 after release.
    do_reset(8'h00);
    rd_en = 1'b1;
    repeat (260) @(negedge clk);
    #1 C = 8'h77;
    rd_en = 1'b0;
    repeat (40) @(negedge clk);
    check("wrap_count", int'(count), 1);
    check("wrap_dout", int'(dout), 8'h77);
    check("wrap_dstamp", int'(dstamp), exps(4));

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
